am_search_ctrl: RTL



---
 rtl/am_search_ctrl.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/am_search_ctrl.sv
// Associative-memory search sequencer: issues row reads with bounded outstanding
// depth, tracks the first-seen maximum score, and reports the winning row.

module am_search_ctrl_chk #(
  parameter int AW              = 13,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic          clk,
  input logic          rst,
  input logic          am_rd_en,
  input logic          am_stall,
  input logic          busy,
  input logic          done,
  input logic [AW-1:0] outstanding
);
  localparam logic [AW-1:0] MAX_OUT = AW'(MAX_OUTSTANDING);

  a_no_read_when_stalled: assert property (@(posedge clk) disable iff (rst)
    am_rd_en |-> !am_stall);

  a_outstanding_bounded: assert property (@(posedge clk) disable iff (rst)
    outstanding <= MAX_OUT);

  a_done_single_cycle: assert property (@(posedge clk) disable iff (rst)
    done |=> !done);

  a_read_only_when_busy: assert property (@(posedge clk) disable iff (rst)
    am_rd_en |-> busy);
endmodule

module am_search_ctrl #(
  parameter int N               = 2048,
  parameter int AM_ADDR_WIDTH   = 13,
  parameter int SCORE_W         = $clog2(N),
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [AM_ADDR_WIDTH-1:0] base_addr_i,
  input  logic [AM_ADDR_WIDTH-1:0] num_rows_i,
  input  logic                     abort_i,
  input  logic                     am_stall_i,
  output logic                     am_rd_en_o,
  output logic [AM_ADDR_WIDTH-1:0] am_addr_o,
  input  logic                     res_valid_i,
  input  logic [SCORE_W-1:0]       res_score_i,
  input  logic [AM_ADDR_WIDTH-1:0] res_addr_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [AM_ADDR_WIDTH-1:0] best_addr_o,
  output logic [SCORE_W-1:0]       best_score_o,
  output logic                     err_o
);
  localparam int AW = AM_ADDR_WIDTH;
  localparam logic [AW-1:0] ZERO    = AW'(0);
  localparam logic [AW-1:0] ONE     = AW'(1);
  localparam logic [AW-1:0] MAX_OUT = AW'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  logic [AW-1:0] base;
  logic [AW-1:0] num;
  logic [AW-1:0] issued;
  logic [AW-1:0] received;
  logic [AW-1:0] outstanding;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] last_addr;
  logic          accept;
  logic          fire;
  logic          in_search;
  logic          res_take;
  logic          stray;
  logic          load_best;

  assign accept      = (state == IDLE) && start_i;
  assign outstanding = issued - received;
  assign rd_addr     = base + issued;
  assign in_search   = (state == ISSUE) || (state == WAIT) || (state == FLUSH);

  // abort_i gates the strobe combinationally so no read escapes in the abort cycle
  assign fire = (state == ISSUE) && !am_stall_i && !abort_i &&
                (outstanding < MAX_OUT) && (issued != num);

  // A result with nothing in flight can only be stray, whatever the state
  assign res_take  = res_valid_i && in_search && (outstanding != ZERO);
  assign stray     = res_valid_i && !res_take;
  assign load_best = res_take && (state != FLUSH) &&
                     ((received == ZERO) || (res_score_i > best_score_o));

  assign am_rd_en_o = fire;
  assign am_addr_o  = fire ? rd_addr : last_addr;

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_i) begin
          if (num_rows_i == ZERO) begin
            state_next = DONE;
          end else begin
            state_next = ISSUE;
          end
        end else begin
          state_next = IDLE;
        end
      end
      ISSUE: begin
        if (abort_i) begin
          state_next = FLUSH;
        end else if (fire && ((issued + ONE) == num)) begin
          state_next = WAIT;
        end else begin
          state_next = ISSUE;
        end
      end
      WAIT: begin
        if (abort_i) begin
          state_next = FLUSH;
        end else if (res_take && ((received + ONE) == num)) begin
          state_next = DONE;
        end else begin
          state_next = WAIT;
        end
      end
      FLUSH: begin
        if ((outstanding == ZERO) || (res_take && (outstanding == ONE))) begin
          state_next = IDLE;
        end else begin
          state_next = FLUSH;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Search window and issue/receive counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      base     <= ZERO;
      num      <= ZERO;
      issued   <= ZERO;
      received <= ZERO;
    end else if (accept) begin
      base     <= base_addr_i;
      num      <= num_rows_i;
      issued   <= ZERO;
      received <= ZERO;
    end else begin
      if (fire) begin
        issued <= issued + ONE;
      end
      if (res_take) begin
        received <= received + ONE;
      end
    end
  end

  // Last issued address, shown on am_addr_o between fires
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_addr <= ZERO;
    end else if (fire) begin
      last_addr <= rd_addr;
    end
  end

  // Argmax tracking; strict compare keeps the earliest row on ties
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      best_addr_o  <= ZERO;
      best_score_o <= SCORE_W'(0);
    end else if (accept) begin
      best_addr_o  <= (num_rows_i == ZERO) ? base_addr_i : ZERO;
      best_score_o <= SCORE_W'(0);
    end else if (load_best) begin
      best_addr_o  <= res_addr_i;
      best_score_o <= res_score_i;
    end
  end

  // Sticky protocol error; a stray in the start cycle still raises it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if (stray) begin
      err_o <= 1'b1;
    end else if (accept) begin
      err_o <= 1'b0;
    end
  end

  // Registered status flags
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      busy_o <= (state_next == ISSUE) || (state_next == WAIT) || (state_next == FLUSH);
      done_o <= (state_next == DONE);
    end
  end

  am_search_ctrl_chk #(
    .AW              (AW),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_chk (
    .clk         (clk_i),
    .rst         (rst_i),
    .am_rd_en    (am_rd_en_o),
    .am_stall    (am_stall_i),
    .busy        (busy_o),
    .done        (done_o),
    .outstanding (outstanding)
  );
endmodule
